// File: rtl/fairy_mem_pkg.sv
// Shared encodings for the fairy unified-memory SRAM arbiter: FSM states,
// transaction owners, byte-enable constants and the captured transaction record.
package fairy_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [3:0] CEN_IDLE = 4'b1111;
  localparam logic [3:0] CEN_WORD = 4'b0000;

  typedef struct packed {
    owner_e      owner;
    logic        wr;
    logic [3:0]  cen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xact_t;

  localparam xact_t XACT_RST = '{
    owner: OWN_INST,
    wr:    1'b0,
    cen:   CEN_IDLE,
    addr:  32'h0,
    wdata: 32'h0
  };

  // A data request with every byte lane disabled completes without touching the SRAM.
  function automatic logic is_noop(input logic [3:0] cen);
    return cen == CEN_IDLE;
  endfunction

endpackage

// File: rtl/fairy_sram_arb_pick.sv
// Priority decision between inst and data requesters: data wins by default,
// inst is forced after STARVE_LIMIT consecutive data wins over a pending inst.
module fairy_sram_arb_pick
  import fairy_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic inst_req,
  input  logic data_req,
  output logic pick_inst,
  output logic pick_data
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the block infers a latch.
    pick_inst    = 1'b0;
    pick_data    = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (arb_en) begin
      if (inst_req && data_req) begin
        if (starve_cnt_q >= LIMIT) begin
          pick_inst    = 1'b1;
          starve_cnt_d = '0;
        end else begin
          pick_data    = 1'b1;
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end else if (inst_req) begin
        pick_inst    = 1'b1;
        starve_cnt_d = '0;
      end else if (data_req) begin
        // An uncontested data win says nothing about inst starvation.
        pick_data = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fairy_sram_arbiter.sv
// Shares one SRAM port between the fetch-stage inst requester and the mem-stage
// data requester; one outstanding transaction, IDLE -> REQ -> (RESP) -> DONE.
module fairy_sram_arbiter
  import fairy_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_cen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic [3:0]  sram_cen,
  output logic        sram_wr,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_ack,
  input  logic        sram_rrdy,
  input  logic [31:0] sram_rdata,
  output logic        busy
);

  state_e      state_q, state_d;
  xact_t       xact_q, xact_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        rd_cap;
  logic        pick_inst, pick_data;
  logic        arb_en;

  assign arb_en = (state_q == IDLE);

  fairy_sram_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .clk      (aclk),
    .rst_n    (areset_n),
    .arb_en   (arb_en),
    .inst_req (inst_req),
    .data_req (data_req),
    .pick_inst(pick_inst),
    .pick_data(pick_data)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= IDLE;
      xact_q       <= XACT_RST;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      xact_q       <= xact_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xact_d  = xact_q;
    rd_cap  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_inst) begin
          xact_d  = '{owner: OWN_INST, wr: 1'b0, cen: CEN_WORD,
                      addr: inst_addr, wdata: 32'h0};
          state_d = REQ;
        end else if (pick_data) begin
          xact_d  = '{owner: OWN_DATA, wr: data_wr, cen: data_cen,
                      addr: data_addr, wdata: data_wdata};
          state_d = is_noop(data_cen) ? DONE : REQ;
        end
      end
      REQ: begin
        if (sram_ack) begin
          if (xact_q.wr) begin
            state_d = DONE;
          end else if (sram_rrdy) begin
            rd_cap  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (sram_rrdy) begin
          rd_cap  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lands only in the owner's register; the other requester's value is held.
  always_comb begin
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (rd_cap) begin
      if (xact_q.owner == OWN_INST) begin
        inst_rdata_d = sram_rdata;
      end else begin
        data_rdata_d = sram_rdata;
      end
    end
  end

  always_comb begin
    sram_cen = CEN_IDLE;
    sram_wr  = 1'b0;
    if (state_q == REQ) begin
      sram_cen = xact_q.cen;
      sram_wr  = xact_q.wr;
    end
  end

  assign sram_addr   = xact_q.addr;
  assign sram_wdata  = xact_q.wdata;
  assign inst_gnt    = pick_inst;
  assign data_gnt    = pick_data;
  assign inst_rvalid = (state_q == DONE) && (xact_q.owner == OWN_INST);
  assign data_done   = (state_q == DONE) && (xact_q.owner == OWN_DATA);
  assign inst_rdata  = inst_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fairy_sram_arbiter.sv
// Directed bench for fairy_sram_arbiter: cycle-exact stimulus in one initial block,
// completions matched against a scoreboard queue by a negedge monitor.
module tb_fairy_sram_arbiter;

  logic        aclk;
  logic        areset_n;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_cen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_done;
  logic [31:0] data_rdata;
  logic [3:0]  sram_cen;
  logic        sram_wr;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ack;
  logic        sram_rrdy;
  logic [31:0] sram_rdata;
  logic        busy;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } sb_item_t;

  sb_item_t    sb_q[$];
  sb_item_t    mon_it;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_inst_rd = '0;
  logic [31:0] exp_data_rd = '0;

  fairy_sram_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_W       (3)
  ) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_gnt   (inst_gnt),
    .inst_rvalid(inst_rvalid),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_cen   (data_cen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_done  (data_done),
    .data_rdata (data_rdata),
    .sram_cen   (sram_cen),
    .sram_wr    (sram_wr),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ack   (sram_ack),
    .sram_rrdy  (sram_rrdy),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  task automatic push(input bit is_data, input logic [31:0] rdata);
    sb_item_t it;
    it.is_data = is_data;
    it.rdata   = rdata;
    sb_q.push_back(it);
  endtask

  always @(negedge aclk) begin
    if (inst_rvalid || data_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_completion", {30'b0, inst_rvalid, data_done}, 32'h0);
      end else begin
        mon_it = sb_q.pop_front();
        check("cmpl_owner", {30'b0, inst_rvalid, data_done},
              mon_it.is_data ? 32'h1 : 32'h2);
        check("cmpl_rdata", mon_it.is_data ? data_rdata : inst_rdata, mon_it.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n   = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = '0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_cen   = 4'b1111;
    data_addr  = '0;
    data_wdata = '0;
    sram_ack   = 1'b0;
    sram_rrdy  = 1'b0;
    sram_rdata = '0;

    // Reset state
    #3;
    check("rst_sram_cen", sram_cen, 32'hF);
    check("rst_sram_wr", sram_wr, 32'h0);
    check("rst_sram_addr", sram_addr, 32'h0);
    check("rst_sram_wdata", sram_wdata, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_pulses", {inst_gnt, inst_rvalid, data_gnt, data_done}, 32'h0);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    #9 areset_n = 1'b1;

    // Lone inst read, ack and rrdy in cycle 1
    step();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    sample();
    check("t1_inst_gnt", {inst_gnt, data_gnt}, 32'h2);
    push(1'b0, 32'h3C1D_0001);
    exp_inst_rd = 32'h3C1D_0001;
    step();
    inst_req   = 1'b0;
    sram_ack   = 1'b1;
    sram_rrdy  = 1'b1;
    sram_rdata = 32'h3C1D_0001;
    sample();
    check("t1_sram_addr", sram_addr, 32'hBFC0_0000);
    check("t1_sram_cen", sram_cen, 32'h0);
    check("t1_sram_wr", sram_wr, 32'h0);
    step();
    sram_ack  = 1'b0;
    sram_rrdy = 1'b0;
    sample();
    check("t1_inst_rvalid", inst_rvalid, 32'h1);
    check("t1_sram_idle", sram_cen, 32'hF);

    // Data write, ack delayed 3 cycles
    step();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_cen   = 4'b1100;
    data_addr  = 32'h0000_0010;
    data_wdata = 32'hDEAD_BEEF;
    sample();
    check("t2_data_gnt", {inst_gnt, data_gnt}, 32'h1);
    push(1'b1, exp_data_rd);
    for (int i = 0; i < 3; i++) begin
      step();
      data_req = 1'b0;
      sample();
      check($sformatf("t2_hold_cen_%0d", i), sram_cen, 32'hC);
      check($sformatf("t2_hold_wr_%0d", i), sram_wr, 32'h1);
      check($sformatf("t2_hold_addr_%0d", i), sram_addr, 32'h10);
      check($sformatf("t2_hold_wdata_%0d", i), sram_wdata, 32'hDEAD_BEEF);
      check($sformatf("t2_no_done_%0d", i), data_done, 32'h0);
    end
    step();
    sram_ack = 1'b1;
    sample();
    check("t2_ack_cycle_cen", sram_cen, 32'hC);
    check("t2_ack_cycle_done", data_done, 32'h0);
    step();
    sram_ack = 1'b0;
    sample();
    check("t2_data_done", data_done, 32'h1);
    check("t2_post_ack_cen", sram_cen, 32'hF);
    check("t2_post_ack_wr", sram_wr, 32'h0);
    step();
    sample();
    check("t2_idle_busy", busy, 32'h0);

    // Both requesters held: D D D D I D D D D I
    step();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_1000;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_cen  = 4'b0000;
    data_addr = 32'h0000_2000;
    for (int k = 0; k < 10; k++) begin
      sample();
      check($sformatf("t3_order_%0d", k), {30'b0, inst_gnt, data_gnt},
            (k % 5 == 4) ? 32'h2 : 32'h1);
      if (k % 5 == 4) begin
        exp_inst_rd = 32'hA000_0000 + 32'(k);
        push(1'b0, exp_inst_rd);
      end else begin
        exp_data_rd = 32'hA000_0000 + 32'(k);
        push(1'b1, exp_data_rd);
      end
      step();
      if (k == 9) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
      sram_ack   = 1'b1;
      sram_rrdy  = 1'b1;
      sram_rdata = 32'hA000_0000 + 32'(k);
      sample();
      step();
      sram_ack  = 1'b0;
      sram_rrdy = 1'b0;
      sample();
      check($sformatf("t3_busy_done_%0d", k), busy, 32'h1);
      if (k != 9) step();
    end

    // Data read, rrdy 5 cycles after ack, spurious ack in RESP
    step();
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_cen  = 4'b0000;
    data_addr = 32'h0000_0020;
    sample();
    check("t4_data_gnt", {inst_gnt, data_gnt}, 32'h1);
    exp_data_rd = 32'hCAFE_F00D;
    push(1'b1, exp_data_rd);
    step();
    data_req   = 1'b0;
    sram_ack   = 1'b1;
    sram_rdata = 32'h1111_1111;
    sample();
    check("t4_req_cen", sram_cen, 32'h0);
    check("t4_req_addr", sram_addr, 32'h20);
    step();
    sram_ack = 1'b0;
    sample();
    check("t4_resp_cen", sram_cen, 32'hF);
    check("t4_resp_busy", busy, 32'h1);
    step();
    sram_ack = 1'b1;
    sample();
    check("t4_spurious_ack_done", data_done, 32'h0);
    check("t4_spurious_ack_busy", busy, 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      sram_ack = 1'b0;
      sample();
      check($sformatf("t4_wait_done_%0d", i), data_done, 32'h0);
    end
    step();
    sram_rrdy  = 1'b1;
    sram_rdata = 32'hCAFE_F00D;
    sample();
    check("t4_rrdy_cycle_done", data_done, 32'h0);
    step();
    sram_rrdy  = 1'b0;
    sram_rdata = 32'h2222_2222;
    sample();
    check("t4_data_done", data_done, 32'h1);
    step();
    sample();
    check("t4_single_done", data_done, 32'h0);
    check("t4_data_rdata_hold", data_rdata, 32'hCAFE_F00D);
    check("t4_inst_rdata_hold", inst_rdata, exp_inst_rd);

    // Reset while in RESP
    step();
    data_req  = 1'b1;
    data_addr = 32'h0000_0030;
    sample();
    check("t5_data_gnt", data_gnt, 32'h1);
    step();
    data_req = 1'b0;
    sram_ack = 1'b1;
    sample();
    step();
    sram_ack = 1'b0;
    sample();
    check("t5_resp_busy", busy, 32'h1);
    #2 areset_n = 1'b0;
    #1;
    check("t5_async_cen", sram_cen, 32'hF);
    check("t5_async_busy", busy, 32'h0);
    check("t5_async_addr", sram_addr, 32'h0);
    check("t5_async_data_rdata", data_rdata, 32'h0);
    exp_inst_rd = '0;
    exp_data_rd = '0;
    step();
    sram_rrdy  = 1'b1;
    sram_rdata = 32'hBAD0_BAD0;
    step();
    areset_n = 1'b1;
    sample();
    check("t5_stray_rrdy_done", data_done, 32'h0);
    check("t5_stray_rrdy_busy", busy, 32'h0);
    step();
    sram_rrdy = 1'b0;
    sample();
    check("t5_no_done_after_rst", data_done, 32'h0);
    step();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0100;
    sample();
    check("t5_inst_gnt", {inst_gnt, data_gnt}, 32'h2);
    exp_inst_rd = 32'h55AA_55AA;
    push(1'b0, exp_inst_rd);
    step();
    inst_req   = 1'b0;
    sram_ack   = 1'b1;
    sram_rrdy  = 1'b1;
    sram_rdata = 32'h55AA_55AA;
    sample();
    check("t5_sram_addr", sram_addr, 32'h100);
    check("t5_sram_cen", sram_cen, 32'h0);
    step();
    sram_ack  = 1'b0;
    sram_rrdy = 1'b0;
    sample();
    check("t5_inst_rvalid", inst_rvalid, 32'h1);

    // No-op data request
    step();
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_cen  = 4'b1111;
    data_addr = 32'h0000_0040;
    sample();
    check("t6_data_gnt", data_gnt, 32'h1);
    check("t6_gnt_cen", sram_cen, 32'hF);
    push(1'b1, exp_data_rd);
    step();
    data_req = 1'b0;
    sample();
    check("t6_data_done", data_done, 32'h1);
    check("t6_done_cen", sram_cen, 32'hF);
    check("t6_done_wr", sram_wr, 32'h0);
    step();
    sram_ack = 1'b1;
    sample();
    check("t6_idle_busy", busy, 32'h0);
    check("t6_idle_cen", sram_cen, 32'hF);
    check("t6_data_rdata_hold", data_rdata, exp_data_rd);
    step();
    sram_ack = 1'b0;
    sample();
    check("t6_stray_ack_busy", busy, 32'h0);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fairy_sram_arbiter.md
Name: fairy_sram_arbiter

Overview:
- Shares one physical SRAM port between the fetch-stage instruction requester and the mem-stage data requester.
- Gives the core unified instruction/data memory behind the existing cen/wr/addr/wdata/ack/rrdy/rdata SRAM protocol.
- Sits between the stage logic and the SRAM, and allows one outstanding transaction at a time.
- Default priority goes to data; a starvation counter guarantees instruction forward progress.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending before inst is forced.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- inst_req  in  1  instruction read request, level, held until inst_gnt
- inst_addr  in  32  instruction address
- inst_gnt  out  1  one-cycle pulse: inst request captured
- inst_rvalid  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request, level, held until data_gnt
- data_wr  in  1  1 = write, 0 = read
- data_cen  in  4  active-low byte enables
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_gnt  out  1  one-cycle pulse: data request captured
- data_done  out  1  one-cycle pulse: data transaction complete (read data valid when it was a read)
- data_rdata  out  32  data read data
- sram_cen  out  4  active-low byte enables; 4'b1111 = idle
- sram_wr  out  1  write strobe
- sram_addr  out  32  address
- sram_wdata  out  32  write data
- sram_ack  in  1  SRAM accepted the request
- sram_rrdy  in  1  read data valid
- sram_rdata  in  32  read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, areset_n = 0):
  - state = IDLE, starve_cnt = 0.
  - sram_cen = 4'b1111; sram_wr, sram_addr, sram_wdata = 0.
  - All gnt/rvalid/done pulses = 0; inst_rdata, data_rdata = 0.
  - A reset mid-transaction abandons it; no done/rvalid is ever issued for it.
- Arbitration, evaluated only in IDLE:
  - Both requests pending and starve_cnt < STARVE_LIMIT: data wins and starve_cnt increments.
  - Both pending and starve_cnt == STARVE_LIMIT: inst wins and starve_cnt clears.
  - Single requester: that requester wins. An inst win always clears starve_cnt. A lone data win leaves starve_cnt unchanged.
- Capture cycle (IDLE with a request present):
  - The winner's gnt pulses combinationally in that cycle.
  - Its fields are registered: owner, wr, cen (inst always uses 4'b0000, wr = 0), addr, wdata.
  - Next state is REQ.
  - Data request with data_cen == 4'b1111 (no-op): data_gnt pulses, state goes to DONE, and no SRAM access occurs.
- REQ:
  - sram_* are driven from the capture registers and held stable until sram_ack.
  - Write with ack: go to DONE.
  - Read with ack and rrdy in the same cycle: capture sram_rdata, go to DONE.
  - Read with ack only: go to RESP.
  - From the cycle after ack, sram_cen = 4'b1111 and sram_wr = 0.
- RESP: sram idle. On sram_rrdy, capture sram_rdata into the owner's rdata register and go to DONE.
- DONE (one cycle):
  - inst_rvalid pulses if the owner is inst; data_done pulses if the owner is data.
  - Go to IDLE.
  - A requester may present a new request in this cycle; it is evaluated in the following IDLE cycle.
- Latency, with ack and rrdy arriving at the earliest point:
  - gnt in cycle 0, SRAM access in cycle 1, done/rvalid in cycle 2.
  - Back-to-back throughput: one transaction per 3 cycles.
- Stray inputs: sram_ack outside REQ is ignored; sram_rrdy outside REQ/RESP is ignored.
- Requester contract: inputs change only after gnt; the arbiter does not check this.
- Read data hold: the rdata outputs hold their value until the next read completes for the same requester.

Decomposition:
- Package fairy_mem_pkg holds:
  - state encoding: IDLE = 0, REQ = 1, RESP = 2, DONE = 3
  - owner encoding: OWN_INST = 0, OWN_DATA = 1
  - CEN_IDLE = 4'b1111, CEN_WORD = 4'b0000
- Sub-module fairy_sram_arb_pick: combinational priority and starvation decision plus the starve_cnt register.
- The FSM and datapath registers stay in the top.

Test Plan:
- Lone inst read at 0xBFC00000, sram_ack and rrdy both in cycle 1, rdata 0x3C1D0001 -> inst_gnt in cycle 0, sram_addr = 0xBFC00000 with cen 0000 in cycle 1, inst_rvalid with 0x3C1D0001 in cycle 2.
- Data write to 0x00000010, cen 1100, wdata 0xDEADBEEF, ack delayed 3 cycles -> sram outputs held stable for 3 cycles, data_done 1 cycle after ack, rrdy never needed.
- inst_req and data_req both held continuously, STARVE_LIMIT = 4 -> grant order D, D, D, D, I, D, D, D, D, I.
- Data read where rrdy arrives 5 cycles after ack, with a spurious sram_ack in RESP -> single data_done, data_rdata = sram_rdata sampled at rrdy, spurious ack ignored.
- areset_n dropped while in RESP -> sram_cen = 1111 immediately (asynchronous), busy = 0, no data_done after reset release; next request proceeds normally.
- Data request with cen 1111 -> data_gnt, then data_done 1 cycle later, sram_cen remains 1111 throughout.
